maze_nav_ctrl: RTL and testbench

- Game-play controller that sequences the maze renderer.
- Owns the character position (char_x/char_y), the scrolling viewport origin (x_coord/y_coord) and the renderer enable.
- Consumes debounced direction buttons and checks each move against the path bitmap. Moves are applied only once per video frame, so the renderer never sees a mid-frame position change.
- Sits between the button debouncers, the maze generator (path_data, dimensions) and the renderer.

---
 rtl/maze_nav_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_maze_nav_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_nav_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : maze_nav_ctrl
// Description : Game-play controller for the maze renderer. Owns the
//               character tile position, the scrolling viewport origin and
//               the renderer enable. Button moves are checked against the
//               path bitmap and applied at most once per video frame.
// Ports       : clk, reset (async, active-low)
//               start            - pulse, (re)start game with current maze
//               vsync            - frame event on its 0->1 transition
//               btn_*            - debounced direction levels
//               path_data        - open-tile bitmap, bit x + 64*y
//               maze_*/tile_*    - maze size in tiles, log2 tile pixel size
//               start_*/goal_*   - tile coordinates
//               char_x/char_y    - character tile position
//               x_coord/y_coord  - viewport origin in tiles
//               enable/solved/busy
// Revision    : 1.0 - initial release
// ============================================================================
module maze_nav_ctrl #(
  parameter int MOVE_DELAY = 4,
  parameter int MARGIN     = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          vsync,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic [8191:0] path_data,
  input  logic [6:0]    maze_width,
  input  logic [6:0]    maze_height,
  input  logic [6:0]    tile_width,
  input  logic [6:0]    tile_height,
  input  logic [6:0]    start_x,
  input  logic [6:0]    start_y,
  input  logic [6:0]    goal_x,
  input  logic [6:0]    goal_y,
  output logic [6:0]    char_x,
  output logic [6:0]    char_y,
  output logic [6:0]    x_coord,
  output logic [6:0]    y_coord,
  output logic          enable,
  output logic          solved,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PLAY   = 3'd2,
    S_CHECK  = 3'd3,
    S_MOVE   = 3'd4,
    S_SCROLL = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [1:0]  c_dir_up    = 2'd0;
  localparam logic [1:0]  c_dir_down  = 2'd1;
  localparam logic [1:0]  c_dir_left  = 2'd2;
  localparam logic [1:0]  c_dir_right = 2'd3;
  localparam logic [3:0]  c_delay     = 4'(MOVE_DELAY);
  localparam logic [10:0] c_margin    = 11'(MARGIN);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_dir;
  logic [3:0]  r_cooldown;
  logic        r_vsync_prev;

  logic        w_frame;
  logic        w_any_btn;
  logic [1:0]  w_dir_sel;
  logic [9:0]  w_vis_w;
  logic [9:0]  w_vis_h;
  logic        w_fit_x;
  logic        w_fit_y;
  logic [7:0]  w_tgt_x;
  logic [7:0]  w_tgt_y;
  logic        w_underflow;
  logic [13:0] w_index;
  logic        w_legal;
  logic        w_at_goal;

  // Viewport origin at game start: centre on the start tile, saturating
  // at both maze edges (signed so a left-of-zero result clamps to 0).
  function automatic logic [6:0] load_origin(input logic [6:0] pos,
                                             input logic [9:0] vis,
                                             input logic [6:0] size);
    logic signed [11:0] lo;
    logic signed [11:0] hi;
    lo = $signed({5'b0, pos}) - $signed({3'b0, vis[9:1]});
    hi = $signed({5'b0, size}) - $signed({2'b0, vis});
    if (lo < 12'sd0)     load_origin = 7'd0;
    else if (lo > hi)    load_origin = hi[6:0];
    else                 load_origin = lo[6:0];
  endfunction

  // One-tile scroll step. The right-edge test is rearranged as
  // pos + MARGIN >= org + vis so nothing goes negative.
  function automatic logic [6:0] scroll_origin(input logic [6:0] pos,
                                               input logic [6:0] org,
                                               input logic [9:0] vis,
                                               input logic [6:0] size);
    logic [10:0] p;
    logic [10:0] o;
    logic [10:0] v;
    logic [10:0] s;
    p = {4'b0, pos};
    o = {4'b0, org};
    v = {1'b0, vis};
    s = {4'b0, size};
    scroll_origin = org;
    if ((p < o + c_margin) && (org != 7'd0))
      scroll_origin = org - 7'd1;
    else if ((p + c_margin >= o + v) && (o + v < s))
      scroll_origin = org + 7'd1;
  endfunction

  assign w_frame   = vsync & ~r_vsync_prev;
  assign w_any_btn = btn_up | btn_down | btn_left | btn_right;
  assign w_vis_w   = 10'd640 >> tile_width;
  assign w_vis_h   = 10'd480 >> tile_height;
  assign w_fit_x   = ({3'b0, maze_width}  <= w_vis_w);
  assign w_fit_y   = ({3'b0, maze_height} <= w_vis_h);
  assign w_at_goal = (char_x == goal_x) && (char_y == goal_y);

  always_comb begin
    w_dir_sel = c_dir_right;
    if (btn_up)        w_dir_sel = c_dir_up;
    else if (btn_down) w_dir_sel = c_dir_down;
    else if (btn_left) w_dir_sel = c_dir_left;
  end

  // Target tile in 8 bits so a step past 127 is still caught by the
  // bounds compare instead of wrapping.
  always_comb begin
    w_tgt_x     = {1'b0, char_x};
    w_tgt_y     = {1'b0, char_y};
    w_underflow = 1'b0;
    case (r_dir)
      c_dir_up: begin
        if (char_y == 7'd0) w_underflow = 1'b1;
        else                w_tgt_y = {1'b0, char_y} - 8'd1;
      end
      c_dir_down: w_tgt_y = {1'b0, char_y} + 8'd1;
      c_dir_left: begin
        if (char_x == 7'd0) w_underflow = 1'b1;
        else                w_tgt_x = {1'b0, char_x} - 8'd1;
      end
      default: w_tgt_x = {1'b0, char_x} + 8'd1;
    endcase
  end

  assign w_index = {w_tgt_y, 6'b0} + {6'b0, w_tgt_x};
  assign w_legal = ~w_underflow
                 & (w_tgt_x < {1'b0, maze_width})
                 & (w_tgt_y < {1'b0, maze_height})
                 & ~w_index[13]
                 & path_data[w_index[12:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    enable = (r_state != S_IDLE);
    busy   = (r_state == S_LOAD) || (r_state == S_CHECK) ||
             (r_state == S_MOVE) || (r_state == S_SCROLL);
    if (start) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE:   w_next = S_IDLE;
        S_LOAD:   w_next = S_PLAY;
        S_PLAY:   if (w_frame && w_any_btn && (r_cooldown == 4'd0)) w_next = S_CHECK;
        S_CHECK:  w_next = w_legal ? S_MOVE : S_PLAY;
        S_MOVE:   w_next = S_SCROLL;
        S_SCROLL: w_next = w_at_goal ? S_DONE : S_PLAY;
        S_DONE:   w_next = S_DONE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Datapath. A start pulse suppresses the current state's update since
  // LOAD rewrites everything on the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vsync_prev <= 1'b0;
      r_dir        <= c_dir_up;
      r_cooldown   <= 4'd0;
      char_x       <= 7'd0;
      char_y       <= 7'd0;
      x_coord      <= 7'd0;
      y_coord      <= 7'd0;
      solved       <= 1'b0;
    end else begin
      r_vsync_prev <= vsync;
      if (!start) begin
        case (r_state)
          S_LOAD: begin
            char_x     <= start_x;
            char_y     <= start_y;
            solved     <= 1'b0;
            r_cooldown <= 4'd0;
            x_coord    <= w_fit_x ? 7'd0 : load_origin(start_x, w_vis_w, maze_width);
            y_coord    <= w_fit_y ? 7'd0 : load_origin(start_y, w_vis_h, maze_height);
          end
          S_PLAY: begin
            if (!w_any_btn)
              r_cooldown <= 4'd0;
            else if (w_frame) begin
              if (r_cooldown != 4'd0) r_cooldown <= r_cooldown - 4'd1;
              else                    r_dir      <= w_dir_sel;
            end
          end
          S_MOVE: begin
            char_x     <= w_tgt_x[6:0];
            char_y     <= w_tgt_y[6:0];
            r_cooldown <= c_delay;
          end
          S_SCROLL: begin
            x_coord <= w_fit_x ? 7'd0 : scroll_origin(char_x, x_coord, w_vis_w, maze_width);
            y_coord <= w_fit_y ? 7'd0 : scroll_origin(char_y, y_coord, w_vis_h, maze_height);
            if (w_at_goal) solved <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maze_nav_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_maze_nav_ctrl
// Description : Self-checking bench for maze_nav_ctrl with a frame-level
//               reference model of the game rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maze_nav_ctrl;

  localparam int MOVE_DELAY = 4;
  localparam int MARGIN     = 2;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          start     = 1'b0;
  logic          vsync     = 1'b0;
  logic          btn_up    = 1'b0;
  logic          btn_down  = 1'b0;
  logic          btn_left  = 1'b0;
  logic          btn_right = 1'b0;
  logic [8191:0] path_data = '0;
  logic [6:0]    maze_width  = 7'd8;
  logic [6:0]    maze_height = 7'd8;
  logic [6:0]    tile_width  = 7'd5;
  logic [6:0]    tile_height = 7'd5;
  logic [6:0]    start_x = 7'd0;
  logic [6:0]    start_y = 7'd0;
  logic [6:0]    goal_x  = 7'd0;
  logic [6:0]    goal_y  = 7'd0;
  logic [6:0]    char_x;
  logic [6:0]    char_y;
  logic [6:0]    x_coord;
  logic [6:0]    y_coord;
  logic          enable;
  logic          solved;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (frame granularity)
  int m_cx, m_cy, m_xo, m_yo, m_cool, m_solved, m_en, m_done;

  maze_nav_ctrl #(.MOVE_DELAY(MOVE_DELAY), .MARGIN(MARGIN)) dut (
    .clk(clk), .reset(reset), .start(start), .vsync(vsync),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .path_data(path_data),
    .maze_width(maze_width), .maze_height(maze_height),
    .tile_width(tile_width), .tile_height(tile_height),
    .start_x(start_x), .start_y(start_y), .goal_x(goal_x), .goal_y(goal_y),
    .char_x(char_x), .char_y(char_y), .x_coord(x_coord), .y_coord(y_coord),
    .enable(enable), .solved(solved), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  function automatic int load_org(int s, int size, int vis);
    int o;
    if (size <= vis) return 0;
    o = s - vis / 2;
    if (o < 0) o = 0;
    if (o > size - vis) o = size - vis;
    return o;
  endfunction

  function automatic int scroll_org(int c, int o, int size, int vis);
    if (size <= vis) return 0;
    if (c < o + MARGIN && o > 0) return o - 1;
    if (c >= o + vis - MARGIN && o + vis < size) return o + 1;
    return o;
  endfunction

  task automatic model_reset();
    m_cx = 0; m_cy = 0; m_xo = 0; m_yo = 0;
    m_cool = 0; m_solved = 0; m_en = 0; m_done = 0;
  endtask

  task automatic model_load();
    m_cx = int'(start_x); m_cy = int'(start_y);
    m_xo = load_org(int'(start_x), int'(maze_width),  640 >> tile_width);
    m_yo = load_org(int'(start_y), int'(maze_height), 480 >> tile_height);
    m_cool = 0; m_solved = 0; m_en = 1; m_done = 0;
  endtask

  task automatic model_frame(input bit u, input bit d, input bit l, input bit r);
    int tx, ty, idx;
    if (m_en == 0 || m_done != 0) return;
    if (!(u | d | l | r)) begin m_cool = 0; return; end
    if (m_cool > 0) begin m_cool--; return; end
    tx = m_cx; ty = m_cy;
    if (u)      ty = ty - 1;
    else if (d) ty = ty + 1;
    else if (l) tx = tx - 1;
    else        tx = tx + 1;
    if (tx < 0 || ty < 0 || tx >= int'(maze_width) || ty >= int'(maze_height)) return;
    idx = tx + 64 * ty;
    if (idx > 8191) return;
    if (path_data[idx] !== 1'b1) return;
    m_cx = tx; m_cy = ty; m_cool = MOVE_DELAY;
    m_xo = scroll_org(m_cx, m_xo, int'(maze_width),  640 >> tile_width);
    m_yo = scroll_org(m_cy, m_yo, int'(maze_height), 480 >> tile_height);
    if (m_cx == int'(goal_x) && m_cy == int'(goal_y)) begin
      m_solved = 1; m_done = 1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic check_all(input string tag);
    chk({tag, ".char_x"},  char_x,  m_cx);
    chk({tag, ".char_y"},  char_y,  m_cy);
    chk({tag, ".x_coord"}, x_coord, m_xo);
    chk({tag, ".y_coord"}, y_coord, m_yo);
    chk({tag, ".solved"},  solved,  m_solved);
    chk({tag, ".enable"},  enable,  m_en);
    chk({tag, ".busy"},    busy,    0);
  endtask

  task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("load.enable", enable, 1);
    chk("load.busy",   busy,   1);
    tick(1);
    model_load();
    check_all("start");
  endtask

  task automatic do_frame(input bit u, input bit d, input bit l, input bit r, input string tag);
    set_btn(u, d, l, r);
    tick(2);
    vsync = 1'b1;
    tick(6);
    vsync = 1'b0;
    tick(2);
    model_frame(u, d, l, r);
    check_all(tag);
  endtask

  // Frame with cycle-exact checks: event sampled on edge n, char on n+2,
  // viewport on n+3.
  task automatic timed_move(input bit u, input bit d, input bit l, input bit r);
    int px, py, pxo, pyo;
    set_btn(u, d, l, r);
    tick(2);
    px = m_cx; py = m_cy; pxo = m_xo; pyo = m_yo;
    model_frame(u, d, l, r);
    vsync = 1'b1;
    tick(1);
    tick(1);
    chk("lat_n1.char_x", char_x, px);
    chk("lat_n1.char_y", char_y, py);
    tick(1);
    chk("lat_n2.char_x",  char_x,  m_cx);
    chk("lat_n2.char_y",  char_y,  m_cy);
    chk("lat_n2.x_coord", x_coord, pxo);
    chk("lat_n2.y_coord", y_coord, pyo);
    tick(1);
    chk("lat_n3.x_coord", x_coord, m_xo);
    chk("lat_n3.y_coord", y_coord, m_yo);
    tick(4);
    vsync = 1'b0;
    tick(2);
    check_all("timed");
  endtask

  initial begin
    int iters;
    int b;
    model_reset();

    // Reset and idle
    reset = 1'b0;
    tick(3);
    check_all("reset");
    reset = 1'b1;
    tick(2);
    check_all("idle");
    do_frame(0, 0, 0, 1, "idle_frame");

    // Small 8x8 maze, fits on screen
    maze_width = 7'd8; maze_height = 7'd8; tile_width = 7'd5; tile_height = 7'd5;
    start_x = 7'd1; start_y = 7'd1; goal_x = 7'd7; goal_y = 7'd7;
    path_data[0]          = 1'b1;
    path_data[0 + 64 * 1] = 1'b1;
    path_data[1 + 64 * 1] = 1'b1;
    path_data[2 + 64 * 1] = 1'b1;
    path_data[3 + 64 * 1] = 1'b1;
    do_start();
    chk("start.char_x_const", char_x, 1);

    timed_move(0, 0, 0, 1);
    chk("first_move.char_x", char_x, 2);

    for (int i = 1; i <= 5; i++) begin
      do_frame(0, 0, 0, 1, "repeat");
      chk("repeat.char_x_const", char_x, (i < 5) ? 2 : 3);
    end

    do_frame(0, 0, 0, 0, "release");
    for (int i = 0; i < 3; i++) begin
      do_frame(1, 0, 0, 0, "wall");
      chk("wall.char_y_const", char_y, 1);
    end

    for (int i = 0; i < 20; i++) do_frame(0, 0, 1, 0, "left");
    chk("left_edge.char_x_const", char_x, 0);

    do_frame(0, 0, 0, 0, "release2");
    do_frame(1, 0, 0, 1, "upright");
    chk("upright.char_y_const", char_y, 0);
    chk("upright.char_x_const", char_x, 0);

    // Goal and restart
    goal_x = 7'd2; goal_y = 7'd1;
    do_start();
    do_frame(0, 0, 0, 1, "goal");
    chk("goal.solved_const", solved, 1);
    for (int i = 0; i < 3; i++) do_frame(0, 0, 0, 1, "done_r");
    for (int i = 0; i < 3; i++) do_frame(0, 1, 0, 0, "done_d");
    chk("done.char_x_const", char_x, 2);
    do_start();
    chk("restart.solved_const", solved, 0);
    chk("restart.char_x_const", char_x, 1);

    // Scrolling: 64x64 maze, 16-pixel tiles -> 40x30 visible
    path_data = '0;
    maze_width = 7'd64; maze_height = 7'd64; tile_width = 7'd4; tile_height = 7'd4;
    start_x = 7'd20; start_y = 7'd15; goal_x = 7'd63; goal_y = 7'd63;
    for (int x = 0; x < 64; x++) path_data[x + 64 * 15] = 1'b1;
    do_start();
    chk("scroll_load.x_coord_const", x_coord, 0);
    chk("scroll_load.y_coord_const", y_coord, 0);
    iters = 0;
    while (m_cx < 37 && iters < 200) begin
      do_frame(0, 0, 0, 1, "scroll_a");
      iters++;
    end
    chk("scroll.char_x_37", char_x, 37);
    do_frame(0, 0, 0, 0, "scroll_rel");
    timed_move(0, 0, 0, 1);
    chk("scroll.char_x_38", char_x, 38);
    chk("scroll.x_coord_1", x_coord, 1);
    iters = 0;
    while (m_cx < 63 && iters < 400) begin
      do_frame(0, 0, 0, 1, "scroll_b");
      chk("scroll.x_coord_le24", (x_coord <= 7'd24), 1);
      iters++;
    end
    for (int i = 0; i < 6; i++) do_frame(0, 0, 0, 1, "scroll_end");
    chk("scroll.char_x_63",  char_x,  63);
    chk("scroll.x_coord_24", x_coord, 24);

    // Randomized mazes and button patterns
    for (int t = 0; t < 6; t++) begin
      maze_width  = 7'($urandom_range(8, 64));
      maze_height = 7'($urandom_range(8, 64));
      tile_width  = 7'($urandom_range(3, 6));
      tile_height = 7'($urandom_range(3, 6));
      for (int k = 0; k < 8192; k++) path_data[k] = ($urandom_range(0, 9) < 7);
      start_x = 7'($urandom_range(0, int'(maze_width) - 1));
      start_y = 7'($urandom_range(0, int'(maze_height) - 1));
      goal_x  = 7'($urandom_range(0, int'(maze_width) - 1));
      goal_y  = 7'($urandom_range(0, int'(maze_height) - 1));
      do_start();
      for (int f = 0; f < 40; f++) begin
        b = $urandom_range(0, 9);
        case (b)
          0:       do_frame(0, 0, 0, 0, "rand");
          1:       do_frame(1, 0, 0, 0, "rand");
          2:       do_frame(0, 1, 0, 0, "rand");
          3:       do_frame(0, 0, 1, 0, "rand");
          4:       do_frame(0, 0, 0, 1, "rand");
          default: do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        endcase
      end
    end

    // Asynchronous reset while in SCROLL
    path_data = '0;
    maze_width = 7'd8; maze_height = 7'd8; tile_width = 7'd5; tile_height = 7'd5;
    start_x = 7'd1; start_y = 7'd1; goal_x = 7'd7; goal_y = 7'd7;
    path_data[1 + 64 * 1] = 1'b1;
    path_data[2 + 64 * 1] = 1'b1;
    do_start();
    set_btn(0, 0, 0, 1);
    tick(2);
    vsync = 1'b1;
    tick(3);
    chk("pre_rst.busy",   busy,   1);
    chk("pre_rst.char_x", char_x, 2);
    #1 reset = 1'b0;
    #1;
    chk("async_rst.char_x", char_x, 0);
    chk("async_rst.char_y", char_y, 0);
    chk("async_rst.enable", enable, 0);
    chk("async_rst.busy",   busy,   0);
    chk("async_rst.solved", solved, 0);
    vsync = 1'b0;
    set_btn(0, 0, 0, 0);
    tick(2);
    reset = 1'b1;
    model_reset();
    tick(2);
    check_all("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
